// File: rtl/snake_move_ctrl_pkg.sv
// Shared direction encodings, button layout and helpers for the snake
// per-player direction controller.
package snake_pkg;

  localparam int unsigned DIR_W = 3;

  typedef enum logic [DIR_W-1:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_LEFT  = 3'd4
  } dir_e;

  // Bit positions inside one player's 4-bit button group {left,down,right,up}
  localparam int unsigned BTN_UP          = 0;
  localparam int unsigned BTN_RIGHT       = 1;
  localparam int unsigned BTN_DOWN        = 2;
  localparam int unsigned BTN_LEFT        = 3;
  localparam int unsigned BTNS_PER_PLAYER = 4;

  function automatic logic [DIR_W-1:0] opposite_dir(input logic [DIR_W-1:0] d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_RIGHT: return DIR_LEFT;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      default:   return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Button/step/direction bundle between the game logic and the direction
// controller; the controller owns the slave side.
interface snake_move_ctrl_if #(
  parameter int unsigned NUM_PLAYERS = 2
);
  import snake_pkg::*;

  logic [4*NUM_PLAYERS-1:0]     btn_n;
  logic                         tick;
  logic                         restart;
  logic [DIR_W*NUM_PLAYERS-1:0] move_dir;
  logic [NUM_PLAYERS-1:0]       dir_changed;
  logic [NUM_PLAYERS-1:0]       pending_valid;

  modport master (
    output btn_n, tick, restart,
    input  move_dir, dir_changed, pending_valid
  );

  modport slave (
    input  btn_n, tick, restart,
    output move_dir, dir_changed, pending_valid
  );

endinterface

// File: rtl/snake_move_ctrl_debounce.sv
// One active-low button: two-flop synchroniser, stable-count debouncer and
// a single-cycle strobe on the debounced press (1->0) transition.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    db_d    = db_q;
    press_d = 1'b0;
    if (sync_q[1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d    = ~db_q;
      cnt_d   = '0;
      press_d = db_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      db_q    <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/snake_move_ctrl.sv
// Per-player direction controller: debounced presses are filtered against
// the no-reversal rule, held as pending, and committed on each game tick.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DEFAULT_DIR     = 2
) (
  input  logic                clock,
  input  logic                reset,
  snake_move_ctrl_if.slave    bus
);

  localparam logic [DIR_W-1:0] DEF_DIR = DIR_W'(DEFAULT_DIR);

  logic [BTNS_PER_PLAYER*NUM_PLAYERS-1:0] press;

  for (genvar b = 0; b < BTNS_PER_PLAYER*NUM_PLAYERS; b++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clock),
      .rst     (reset),
      .btn_n_i (bus.btn_n[b]),
      .press_o (press[b])
    );
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [BTNS_PER_PLAYER-1:0] pp;
    logic [DIR_W-1:0]           move_q, move_d, pend_q, pend_d, sel, ref_dir;
    logic                       pv_q, pv_d, chg_q, chg_d, commit, accept;

    assign pp = press[BTNS_PER_PLAYER*p +: BTNS_PER_PLAYER];

    always_comb begin
      if (pp[BTN_UP])         sel = DIR_UP;
      else if (pp[BTN_RIGHT]) sel = DIR_RIGHT;
      else if (pp[BTN_DOWN])  sel = DIR_DOWN;
      else                    sel = DIR_LEFT;

      // On a committing tick the press is judged against the value landing now
      commit  = bus.tick && pv_q;
      ref_dir = commit ? pend_q : move_q;
      accept  = (|pp) && (sel != opposite_dir(ref_dir));

      move_d = move_q;
      pend_d = pend_q;
      pv_d   = pv_q;
      chg_d  = 1'b0;
      if (bus.restart) begin
        move_d = DEF_DIR;
        pend_d = DEF_DIR;
        pv_d   = 1'b0;
      end else begin
        if (commit) begin
          move_d = pend_q;
          pv_d   = 1'b0;
          chg_d  = (pend_q != move_q);
        end
        if (accept) begin
          pend_d = sel;
          pv_d   = 1'b1;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        move_q <= DEF_DIR;
        pend_q <= DEF_DIR;
        pv_q   <= 1'b0;
        chg_q  <= 1'b0;
      end else begin
        move_q <= move_d;
        pend_q <= pend_d;
        pv_q   <= pv_d;
        chg_q  <= chg_d;
      end
    end

    assign bus.move_dir[DIR_W*p +: DIR_W] = move_q;
    assign bus.dir_changed[p]             = chg_q;
    assign bus.pending_valid[p]           = pv_q;
  end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with DEBOUNCE_CYCLES=4, NUM_PLAYERS=2.
module tb_snake_move_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  snake_move_ctrl_if #(.NUM_PLAYERS(2)) bus ();

  snake_move_ctrl #(
    .NUM_PLAYERS     (2),
    .DEBOUNCE_CYCLES (4),
    .DEFAULT_DIR     (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic hold(input int idx);
    bus.btn_n[idx] = 1'b0;
    step(7);
  endtask

  task automatic release_btn(input int idx);
    bus.btn_n[idx] = 1'b1;
    step(7);
  endtask

  task automatic tick_once();
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
  endtask

  initial begin
    int lat;
    bus.btn_n   = '1;
    bus.tick    = 1'b0;
    bus.restart = 1'b0;
    step(2);
    check("rst_move", 32'(bus.move_dir), 32'o22);
    check("rst_pv", 32'(bus.pending_valid), 0);
    reset = 1'b0;

    // 1: idle ticks change nothing
    for (int i = 0; i < 3; i++) begin
      tick_once();
      check("t1_chg", 32'(bus.dir_changed), 0);
    end
    check("t1_move", 32'(bus.move_dir), 32'o22);
    check("t1_pv", 32'(bus.pending_valid), 0);

    // 2: press latency and commit
    bus.btn_n[0] = 1'b0;
    lat = 0;
    while (bus.pending_valid[0] !== 1'b1 && lat < 20) begin
      step(1);
      lat++;
    end
    check("t2_latency", 32'(lat), 7);
    step(3);
    check("t2_pv_hold", 32'(bus.pending_valid), 32'b01);
    tick_once();
    check("t2_move", 32'(bus.move_dir[2:0]), 1);
    check("t2_chg", 32'(bus.dir_changed), 32'b01);
    check("t2_pv_clr", 32'(bus.pending_valid), 0);
    step(1);
    check("t2_chg_pulse", 32'(bus.dir_changed), 0);
    release_btn(0);

    // 3: reversal rejection
    hold(1);
    check("t3_right_acc", 32'(bus.pending_valid), 32'b01);
    release_btn(1);
    tick_once();
    check("t3_move_right", 32'(bus.move_dir[2:0]), 2);
    check("t3_chg_right", 32'(bus.dir_changed), 32'b01);
    hold(3);
    check("t3_left_rej", 32'(bus.pending_valid), 0);
    release_btn(3);
    tick_once();
    check("t3_move_keep", 32'(bus.move_dir[2:0]), 2);
    check("t3_chg_none", 32'(bus.dir_changed), 0);
    hold(0);
    release_btn(0);
    hold(3);
    release_btn(3);
    check("t3_pv_up", 32'(bus.pending_valid), 32'b01);
    tick_once();
    check("t3_move_up", 32'(bus.move_dir[2:0]), 1);
    check("t3_chg_up", 32'(bus.dir_changed), 32'b01);

    // 4: glitch filtered; simultaneous up+right picks up
    bus.btn_n[1] = 1'b0;
    step(3);
    bus.btn_n[1] = 1'b1;
    step(10);
    check("t4_glitch", 32'(bus.pending_valid), 0);
    bus.btn_n[1:0] = 2'b00;
    step(7);
    check("t4_both_pv", 32'(bus.pending_valid), 32'b01);
    bus.btn_n[1:0] = 2'b11;
    step(7);
    tick_once();
    check("t4_prio_move", 32'(bus.move_dir[2:0]), 1);
    check("t4_prio_chg", 32'(bus.dir_changed), 0);
    check("t4_pv_clr", 32'(bus.pending_valid), 0);

    // 5: press accepted in the tick cycle, judged against pending
    hold(1);
    release_btn(1);
    bus.btn_n[2] = 1'b0;
    step(6);
    bus.tick = 1'b1;
    step(1);
    bus.tick = 1'b0;
    check("t5_commit", 32'(bus.move_dir[2:0]), 2);
    check("t5_chg", 32'(bus.dir_changed), 32'b01);
    check("t5_pv_kept", 32'(bus.pending_valid), 32'b01);
    release_btn(2);
    tick_once();
    check("t5_move_down", 32'(bus.move_dir[2:0]), 3);
    check("t5_chg_down", 32'(bus.dir_changed), 32'b01);

    // 6: player 1 to left, then restart with tick and press
    hold(6);
    release_btn(6);
    tick_once();
    check("t6_p1_down", 32'(bus.move_dir[5:3]), 3);
    hold(7);
    release_btn(7);
    tick_once();
    check("t6_p1_left", 32'(bus.move_dir[5:3]), 4);
    check("t6_p1_chg", 32'(bus.dir_changed), 32'b10);
    bus.btn_n[4] = 1'b0;
    step(6);
    bus.restart = 1'b1;
    bus.tick    = 1'b1;
    step(1);
    bus.restart = 1'b0;
    bus.tick    = 1'b0;
    check("t6_rs_move", 32'(bus.move_dir), 32'o22);
    check("t6_rs_pv", 32'(bus.pending_valid), 0);
    check("t6_rs_chg", 32'(bus.dir_changed), 0);
    release_btn(4);
    check("t6_rs_pv2", 32'(bus.pending_valid), 0);

    // async reset mid-debounce
    hold(2);
    release_btn(2);
    bus.btn_n[5] = 1'b0;
    step(3);
    tick_once();
    check("t6_pre_move", 32'(bus.move_dir[2:0]), 3);
    check("t6_pre_chg", 32'(bus.dir_changed), 32'b01);
    reset = 1'b1;
    #2;
    check("t6_ar_move", 32'(bus.move_dir), 32'o22);
    check("t6_ar_chg", 32'(bus.dir_changed), 0);
    check("t6_ar_pv", 32'(bus.pending_valid), 0);
    bus.btn_n[5] = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);
    check("t6_post_pv", 32'(bus.pending_valid), 0);
    check("t6_post_move", 32'(bus.move_dir), 32'o22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snake_move_ctrl.md
Name: snake_move_ctrl

Overview:
- Parametrised per-player direction controller for the snake game. Replaces the free-running combinational direction latches.
- Per button: synchronises, debounces and edge-detects the active-low direction buttons.
- Enforces the no-reversal rule against the committed direction.
- Commits one new direction per player on each game-step tick. The result feeds the move registers read by the processor regfile.

Parameters:
- NUM_PLAYERS, 2, number of independent players (1..8).
- DEBOUNCE_CYCLES, 50000, consecutive stable clock cycles required before a debounced level changes (1 ms at 50 MHz).
- DEFAULT_DIR, 2, direction loaded at reset/restart (1=up, 2=right, 3=down, 4=left).

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- btn_n  in  4*NUM_PLAYERS  raw active-low buttons. Player p occupies bits [4p+3:4p], ordered {left,down,right,up}.
- tick  in  1  single-cycle game-step strobe.
- restart  in  1  synchronous game restart.
- move_dir  out  3*NUM_PLAYERS  committed direction per player, bits [3p+2:3p], values 1..4.
- dir_changed  out  NUM_PLAYERS  one-cycle pulse when the player's committed direction changed.
- pending_valid  out  NUM_PLAYERS  high while an accepted press awaits the next tick.

Behaviour:
- Reset (async, active-high):
  - move_dir fields = DEFAULT_DIR; pending = DEFAULT_DIR; pending_valid = 0; dir_changed = 0.
  - Synchroniser flops = 1 (released); debounced levels = 1; debounce counters = 0.
- Synchroniser: two flops per button. Latency from btn_n to synchronised level is 2 cycles.
- Debounce, per button, with a counter of width clog2(DEBOUNCE_CYCLES+1):
  - If the synchronised level equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - The debounced level therefore changes exactly DEBOUNCE_CYCLES cycles after a stable change.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count and produces no change.
- Press event: one-cycle strobe on the debounced 1->0 transition. Holding a button produces no further events. Release produces no event.
- Simultaneous press events for the same player in one cycle: priority up > right > down > left. Lower-priority events are discarded.
- Acceptance:
  - A press is rejected if its direction is the opposite of the reference direction (1<->3, 2<->4).
  - The reference direction is the committed move_dir, or the old pending value if tick fires in the same cycle.
  - Accepted press: pending <= dir and pending_valid <= 1. A later accepted press before the tick overwrites pending (last wins).
  - A press equal to the reference direction is accepted but causes no dir_changed at commit.
- Tick:
  - If pending_valid, then move_dir <= pending and pending_valid <= 0.
  - dir_changed is asserted in the cycle after tick iff the new value differs from the old.
  - A press accepted in the tick cycle is stored as pending for the next tick, evaluated against the value being committed.
  - Two quick presses (e.g. up then left while moving right) can never yield a reversal within one step.
- Restart, synchronous, highest priority over tick and presses:
  - Restores DEFAULT_DIR and clears pending_valid and dir_changed.
  - Debounce state is untouched.
- Players are fully independent; a tick applies to all players in the same cycle.
- No backpressure. tick asserted on consecutive cycles is legal.

Decomposition:
- Package snake_pkg holds:
  - DIR_UP=1, DIR_RIGHT=2, DIR_DOWN=3, DIR_LEFT=4, DIR_W=3.
  - An opposite-direction function.
  - The button bit indices within a player group.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES):
  - Contains the synchroniser, counter and press strobe.
  - Instantiated 4*NUM_PLAYERS times via generate.
- Per-player accept/commit logic sits in a generate loop in the top.

Test Plan (DEBOUNCE_CYCLES=4, NUM_PLAYERS=2):
1. Reset, no presses, 3 ticks -> move_dir fields both 2, dir_changed=0, pending_valid=0.
2. P0 up held 10 cycles, then tick -> pending_valid[0] rises exactly 2+4+1 cycles after btn_n fall; after tick move_dir[2:0]=1 and dir_changed[0] pulses for one cycle.
3. P0 moving right, press left, tick -> rejected: pending_valid=0, move_dir stays 2. Then press up, then left before the tick -> after tick move_dir=1 (left rejected, since committed is still right).
4. btn_n glitch low for 3 cycles -> no press event, pending_valid stays 0. Up and right pressed in the same cycle -> pending=1.
5. Press down accepted in the same cycle as a tick while pending=2 -> commits 2, pending=3, pending_valid stays 1; next tick gives move_dir=3.
6. Restart asserted with tick and an accepted press after P1 reaches 4 -> move_dir[5:3]=2, pending_valid=0. Async reset mid-debounce -> all outputs return to reset values immediately.
